sdram_arbiter: RTL and testbench

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

---
 rtl/sdram_arb_pkg.sv | 18 +
 rtl/sdram_arb_tagfifo.sv | 70 +++++++
 rtl/sdram_arbiter.sv | 152 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared definitions for the two-port SDRAM arbiter: default geometry and the
// 1-bit requester id that travels through the read-tag FIFO.
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int ADDR_W_DEF   = 25;  // SDRAM word-address width
    localparam int DATA_W_DEF   = 32;  // data width (byte enables = DATA_W/8)
    localparam int MAX_PEND_DEF = 8;   // outstanding reads, power of two

    // Identifies which requester owns a command or a returning read.
    typedef logic port_id_t;

    localparam port_id_t PORT_M0 = 1'b0;
    localparam port_id_t PORT_M1 = 1'b1;

endpackage

// File: rtl/sdram_arb_tagfifo.sv
// -----------------------------------------------------------------------------
// sdram_arb_tagfifo
// Depth-DEPTH, 1-bit-wide FIFO of requester ids, one entry per read that the
// controller has accepted but not yet answered. Head entry is shown
// combinationally so the return can be routed in the same cycle it arrives.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (empties the FIFO)
//   push, push_id write one id at the tail (caller never pushes when full)
//   pop           drop the head entry (caller never pops when empty)
//   head          id at the head of the queue
//   full, empty   occupancy flags
//   count         number of entries held, 0..DEPTH
// -----------------------------------------------------------------------------
module sdram_arb_tagfifo
    import sdram_arb_pkg::*;
#(
    parameter int DEPTH = MAX_PEND_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  port_id_t                 push_id,
    input  logic                     pop,
    output port_id_t                 head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    port_id_t           mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     cnt;

    // NOTE: the storage array has no reset; only the pointers and count define
    // which entries are valid, so clearing them is enough to empty the FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflow.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: ;  // idle or simultaneous push/pop: count unchanged
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (cnt == (PTR_W+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Round-robin arbiter sharing one SDRAM controller command port between two
// Avalon-style requesters (m0, m1). A command stalled by the controller locks
// the grant until it is accepted. Read ids are queued in a tag FIFO so that
// returning data is steered to the right requester with zero latency.
//
// Ports:
//   clk_clk, reset_reset_n         clock, asynchronous active-low reset
//   mN_address/_byteenable_n/_writedata/_read_n/_write_n   requester N command
//   mN_readdata/_readdatavalid/_waitrequest                requester N response
//   sdram_1_address/_byteenable_n/_writedata/_chipselect/_read_n/_write_n
//                                  command port toward the controller
//   sdram_1_readdata/_readdatavalid/_waitrequest  controller response
//   err_orphan                     sticky: read data arrived with nothing pending
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_PEND = MAX_PEND_DEF
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable_n,
    input  logic [DATA_W-1:0]     m0_writedata,
    input  logic                  m0_read_n,
    input  logic                  m0_write_n,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    output logic                  m0_waitrequest,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable_n,
    input  logic [DATA_W-1:0]     m1_writedata,
    input  logic                  m1_read_n,
    input  logic                  m1_write_n,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic                  m1_waitrequest,
    output logic [ADDR_W-1:0]     sdram_1_address,
    output logic [DATA_W/8-1:0]   sdram_1_byteenable_n,
    output logic [DATA_W-1:0]     sdram_1_writedata,
    output logic                  sdram_1_chipselect,
    output logic                  sdram_1_read_n,
    output logic                  sdram_1_write_n,
    input  logic [DATA_W-1:0]     sdram_1_readdata,
    input  logic                  sdram_1_readdatavalid,
    input  logic                  sdram_1_waitrequest,
    output logic                  err_orphan
);

    localparam int CNT_W = $clog2(MAX_PEND) + 1;

    port_id_t           sel;
    port_id_t           lock_port;
    port_id_t           prio_q;
    logic               lock_q;
    logic               req0, req1;
    logic               sel_read_n, sel_write_n;
    logic               sel_req, sel_rd;
    logic               blocked, issue, accept;
    logic               fifo_push, fifo_pop;
    logic               fifo_full, fifo_empty;
    port_id_t           fifo_head;
    logic [CNT_W-1:0]   pend_count;

    assign req0 = ~m0_read_n | ~m0_write_n;
    assign req1 = ~m1_read_n | ~m1_write_n;

    // NOTE: sel gets a default before the priority chain so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        sel = prio_q;
        if (lock_q)            sel = lock_port;
        else if (req0 && req1) sel = prio_q;
        else if (req0)         sel = PORT_M0;
        else if (req1)         sel = PORT_M1;
    end

    assign sel_read_n  = (sel == PORT_M1) ? m1_read_n  : m0_read_n;
    assign sel_write_n = (sel == PORT_M1) ? m1_write_n : m0_write_n;
    assign sel_req     = ~sel_read_n | ~sel_write_n;
    assign sel_rd      = ~sel_read_n;

    // A read is held back while every tag slot is taken, even if a slot frees
    // up this very cycle; it goes out on the next cycle instead.
    assign blocked = sel_rd & fifo_full;
    // Gating with reset keeps the command port idle while reset is asserted,
    // even though requester inputs are still passed through combinationally.
    assign issue   = reset_reset_n & sel_req & ~blocked;
    assign accept  = issue & ~sdram_1_waitrequest;

    // Address, data and byte enables always follow the selected port; only
    // the strobes are qualified.
    assign sdram_1_address      = (sel == PORT_M1) ? m1_address      : m0_address;
    assign sdram_1_byteenable_n = (sel == PORT_M1) ? m1_byteenable_n : m0_byteenable_n;
    assign sdram_1_writedata    = (sel == PORT_M1) ? m1_writedata    : m0_writedata;
    assign sdram_1_chipselect   = issue;
    assign sdram_1_read_n       = issue ? sel_read_n  : 1'b1;
    assign sdram_1_write_n      = issue ? sel_write_n : 1'b1;

    assign m0_waitrequest = ~(accept && (sel == PORT_M0));
    assign m1_waitrequest = ~(accept && (sel == PORT_M1));

    assign fifo_push = accept & sel_rd;
    assign fifo_pop  = sdram_1_readdatavalid & ~fifo_empty;

    sdram_arb_tagfifo #(
        .DEPTH   (MAX_PEND)
    ) u_tagfifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .push    (fifo_push),
        .push_id (sel),
        .pop     (fifo_pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (pend_count)
    );

    // The full flag and the occupancy count must never disagree.
    assert property (@(posedge clk_clk) disable iff (!reset_reset_n)
        fifo_full == (pend_count == CNT_W'(MAX_PEND)));

    assign m0_readdata      = sdram_1_readdata;
    assign m1_readdata      = sdram_1_readdata;
    assign m0_readdatavalid = fifo_pop && (fifo_head == PORT_M0);
    assign m1_readdatavalid = fifo_pop && (fifo_head == PORT_M1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            lock_q     <= 1'b0;
            lock_port  <= PORT_M0;
            prio_q     <= PORT_M0;
            err_orphan <= 1'b0;
        end else begin
            // A stalled command keeps the grant until the controller takes it.
            if (issue && sdram_1_waitrequest) begin
                lock_q    <= 1'b1;
                lock_port <= sel;
            end else if (accept) begin
                lock_q    <= 1'b0;
            end
            if (accept) prio_q <= ~sel;
            if (sdram_1_readdatavalid && fifo_empty) err_orphan <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Directed bench for sdram_arbiter: a cycle table for arbitration, locking and
// routing, then hand-written sequences for the full tag FIFO, orphan returns
// and reset with reads outstanding.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;

    localparam logic [24:0] A0  = 25'h000_0100;
    localparam logic [24:0] A1  = 25'h000_0200;
    localparam logic [31:0] WD0 = 32'h1111_0000;
    localparam logic [31:0] WD1 = 32'h2222_0000;
    localparam logic [3:0]  BE0 = 4'b0000;
    localparam logic [3:0]  BE1 = 4'b1100;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [24:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable_n, m1_byteenable_n;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_read_n, m0_write_n, m1_read_n, m1_write_n;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        m0_waitrequest, m1_waitrequest;
    logic [24:0] sdram_1_address;
    logic [3:0]  sdram_1_byteenable_n;
    logic [31:0] sdram_1_writedata;
    logic        sdram_1_chipselect, sdram_1_read_n, sdram_1_write_n;
    logic [31:0] sdram_1_readdata;
    logic        sdram_1_readdatavalid, sdram_1_waitrequest;
    logic        err_orphan;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_clk = ~clk_clk;

    sdram_arbiter dut (
        .clk_clk               (clk_clk),
        .reset_reset_n         (reset_reset_n),
        .m0_address            (m0_address),
        .m0_byteenable_n       (m0_byteenable_n),
        .m0_writedata          (m0_writedata),
        .m0_read_n             (m0_read_n),
        .m0_write_n            (m0_write_n),
        .m0_readdata           (m0_readdata),
        .m0_readdatavalid      (m0_readdatavalid),
        .m0_waitrequest        (m0_waitrequest),
        .m1_address            (m1_address),
        .m1_byteenable_n       (m1_byteenable_n),
        .m1_writedata          (m1_writedata),
        .m1_read_n             (m1_read_n),
        .m1_write_n            (m1_write_n),
        .m1_readdata           (m1_readdata),
        .m1_readdatavalid      (m1_readdatavalid),
        .m1_waitrequest        (m1_waitrequest),
        .sdram_1_address       (sdram_1_address),
        .sdram_1_byteenable_n  (sdram_1_byteenable_n),
        .sdram_1_writedata     (sdram_1_writedata),
        .sdram_1_chipselect    (sdram_1_chipselect),
        .sdram_1_read_n        (sdram_1_read_n),
        .sdram_1_write_n       (sdram_1_write_n),
        .sdram_1_readdata      (sdram_1_readdata),
        .sdram_1_readdatavalid (sdram_1_readdatavalid),
        .sdram_1_waitrequest   (sdram_1_waitrequest),
        .err_orphan            (err_orphan)
    );

    // One cycle of stimulus and the outputs expected in that same cycle.
    typedef struct {
        logic        m0_rd, m0_wr, m1_rd, m1_wr;
        logic        sd_wait, sd_rdv;
        logic [31:0] sd_rdata;
        logic        e_cs, e_rd_n, e_wr_n;
        logic        e_src;                 // port whose addr/data/be appear downstream
        logic        e_w0, e_w1, e_v0, e_v1;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later,
    // well clear of the rising edge that commits the cycle.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk_clk);
        m0_read_n             = ~v.m0_rd;
        m0_write_n            = ~v.m0_wr;
        m1_read_n             = ~v.m1_rd;
        m1_write_n            = ~v.m1_wr;
        sdram_1_waitrequest   = v.sd_wait;
        sdram_1_readdatavalid = v.sd_rdv;
        sdram_1_readdata      = v.sd_rdata;
        #1;
        check({tag, ".cs"},   sdram_1_chipselect, v.e_cs);
        check({tag, ".rd_n"}, sdram_1_read_n,     v.e_rd_n);
        check({tag, ".wr_n"}, sdram_1_write_n,    v.e_wr_n);
        check({tag, ".addr"}, sdram_1_address,      v.e_src ? A1  : A0);
        check({tag, ".wd"},   sdram_1_writedata,    v.e_src ? WD1 : WD0);
        check({tag, ".be_n"}, sdram_1_byteenable_n, v.e_src ? BE1 : BE0);
        check({tag, ".w0"},   m0_waitrequest,   v.e_w0);
        check({tag, ".w1"},   m1_waitrequest,   v.e_w1);
        check({tag, ".v0"},   m0_readdatavalid, v.e_v0);
        check({tag, ".v1"},   m1_readdatavalid, v.e_v1);
        check({tag, ".rd0"},  m0_readdata, v.sd_rdata);
        check({tag, ".rd1"},  m1_readdata, v.sd_rdata);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cs"},   sdram_1_chipselect, 1'b0);
        check({tag, ".rd_n"}, sdram_1_read_n,     1'b1);
        check({tag, ".wr_n"}, sdram_1_write_n,    1'b1);
        check({tag, ".w0"},   m0_waitrequest,     1'b1);
        check({tag, ".w1"},   m1_waitrequest,     1'b1);
        check({tag, ".v0"},   m0_readdatavalid,   1'b0);
        check({tag, ".v1"},   m1_readdatavalid,   1'b0);
        check({tag, ".err"},  err_orphan,         1'b0);
    endtask

    task automatic idle_inputs();
        m0_read_n = 1'b1; m0_write_n = 1'b1;
        m1_read_n = 1'b1; m1_write_n = 1'b1;
        sdram_1_waitrequest = 1'b0; sdram_1_readdatavalid = 1'b0;
        sdram_1_readdata = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk_clk);
        idle_inputs();
        reset_reset_n = 1'b0;
        #1 check_reset_outputs("rst");
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
    endtask

    initial begin
        vec_t v;

        m0_address = A0; m0_writedata = WD0; m0_byteenable_n = BE0;
        m1_address = A1; m1_writedata = WD1; m1_byteenable_n = BE1;
        idle_inputs();
        reset_reset_n = 1'b0;

        //             m0r   m0w   m1r   m1w   wait  rdv   rdata          cs    rd_n  wr_n  src   w0    w1    v0    v1
        // Simultaneous reads from reset: m0 first, m1 next, data in issue order.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hBBBB_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        // m0 write hands priority to m1; m1 write then stalls 3 cycles while m0 waits.
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        // m0 read goes out the cycle after m1's write is accepted; writes queue no tag.
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        // Reset state, then release on a falling edge.
        #6 check_reset_outputs("init");
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        #1 check("init.err_after_release", err_orphan, 1'b0);

        for (int i = 0; i < 11; i++) step($sformatf("vec%0d", i), vecs[i]);

        // ---- Full tag FIFO: eight reads fill it, the ninth waits. ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            step($sformatf("fill%0d", i), v);
        end
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        step("full_block", v);
        // Return and new read in the same cycle: still blocked.
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC0DE_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        step("pop_same_cycle", v);
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        step("after_pop", v);
        // Count is back at eight, so the next read blocks again.
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        step("still_full", v);
        check("full.err", err_orphan, 1'b0);
        // Drain all eight; every accept left priority on m1, so m1's fields show.
        for (int i = 0; i < 8; i++) begin
            v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hD000_0000 + 32'(i),
                  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            step($sformatf("drain%0d", i), v);
        end

        // ---- Orphan return: no valid to either port, sticky error. ----
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        step("orphan", v);
        @(posedge clk_clk); #1;
        check("orphan.err_set", err_orphan, 1'b1);
        repeat (3) @(posedge clk_clk);
        #1 check("orphan.err_sticky", err_orphan, 1'b1);

        // ---- Issue-order routing across a wrapped FIFO: m1, m0, m1. ----
        v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        step("ord_rd_m1a", v);
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        step("ord_rd_m0", v);
        v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        step("ord_rd_m1b", v);
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB100_0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        step("ord_ret_m1a", v);
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        step("ord_ret_m0", v);
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hB100_0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        step("ord_ret_m1b", v);

        // ---- Reset with three reads outstanding. ----
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        step("pend_m0a", v);
        v = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        step("pend_m1", v);
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        step("pend_m0b", v);
        // Requests and a return stay active while reset is held.
        @(negedge clk_clk);
        m0_read_n = 1'b0; m1_write_n = 1'b0;
        sdram_1_readdatavalid = 1'b1; sdram_1_readdata = 32'h5555_AAAA;
        reset_reset_n = 1'b0;
        #1 check_reset_outputs("mid_rst0");
        @(negedge clk_clk);
        #1 check_reset_outputs("mid_rst1");
        @(negedge clk_clk);
        idle_inputs();
        reset_reset_n = 1'b1;
        #1 check("rel.err", err_orphan, 1'b0);
        // The discarded tags are gone: the next return is an orphan.
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0BAD_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        step("rel_orphan", v);
        @(posedge clk_clk); #1;
        check("rel_orphan.err_set", err_orphan, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
